// File: rtl/sccb_cfg_pkg.sv
// sccb_cfg_pkg: shared FSM states, table marker codes and delay helper for the SCCB config sequencer.
package sccb_cfg_pkg;
    typedef enum logic [2:0] {START_WAIT, FETCH, DECODE, SEND, DELAY, DONE} state_e;
    localparam logic [15:0] CFG_END = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;
    localparam logic [7:0] DEFAULT_DEVICE_ID = 8'h42;
    // Countdown reload value; a zero delay still spends one cycle in the wait state.
    function automatic logic [31:0] delay_load(input int unsigned d);
        return (d == 0) ? 32'd0 : 32'(d - 1);
    endfunction
endpackage

// File: rtl/sccb_cfg_rom.sv
// sccb_cfg_rom: per-camera register table, one registered read.
module sccb_cfg_rom #(
    parameter int AW = 8,
    parameter logic [16*(2**AW)-1:0] INIT = '1
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [15:0]   data
);
    logic [15:0] data_q;
    always_ff @(posedge clk) data_q <= INIT[{addr, 4'b0000} +: 16];
    assign data = data_q;
endmodule

// File: rtl/sccb_cfg_sequencer.sv
// sccb_cfg_sequencer: walks the register table after a power-up delay and hands each
// {reg, value} write to the SCCB sender with a send/taken handshake.
module sccb_cfg_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID = DEFAULT_DEVICE_ID,
    parameter int ROM_AW = 8,
    parameter int unsigned START_DELAY = 1_000_000,
    parameter int unsigned MARK_DELAY = 500_000,
    parameter logic [16*(2**ROM_AW)-1:0] ROM_INIT = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    output logic [7:0]        cfg_id,
    output logic [7:0]        cfg_reg,
    output logic [7:0]        cfg_value,
    output logic              send,
    input  logic              taken,
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] index
);
    localparam logic [31:0] START_LD = delay_load(START_DELAY);
    localparam logic [31:0] MARK_LD = delay_load(MARK_DELAY);
    state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [ROM_AW-1:0] index_q, index_d;
    logic [7:0] reg_q, reg_d, val_q, val_d;
    logic send_q, send_d, done_q, done_d, adv;
    logic [15:0] rom_data;

    sccb_cfg_rom #(.AW(ROM_AW), .INIT(ROM_INIT)) u_rom (
        .clk  (clk),
        .addr (index_q),
        .data (rom_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        index_d = index_q;
        reg_d = reg_q;
        val_d = val_q;
        send_d = send_q;
        done_d = done_q;
        adv = 1'b0;
        case (state_q)
            START_WAIT: if (cnt_q == 0) state_d = FETCH; else cnt_d = cnt_q - 1;
            FETCH: state_d = DECODE;
            DECODE: begin
                if (rom_data == CFG_END) begin
                    state_d = DONE;
                    done_d = 1'b1;
                end else if (rom_data == CFG_DELAY) begin
                    cnt_d = MARK_LD;
                    state_d = DELAY;
                end else begin
                    {reg_d, val_d} = rom_data;
                    send_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                send_d = ~taken;
                adv = taken;
            end
            DELAY: if (cnt_q == 0) adv = 1'b1; else cnt_d = cnt_q - 1;
            DONE: begin
                if (restart) begin
                    done_d = 1'b0;
                    index_d = '0;
                    cnt_d = START_LD;
                    state_d = START_WAIT;
                end
            end
            default: state_d = START_WAIT;
        endcase
        // The last address is terminal: finish there instead of wrapping to entry 0.
        if (adv) begin
            if (&index_q) begin
                state_d = DONE;
                done_d = 1'b1;
            end else begin
                index_d = index_q + 1'b1;
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= START_WAIT;
            cnt_q <= START_LD;
            index_q <= '0;
            reg_q <= '0;
            val_q <= '0;
            send_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            index_q <= index_d;
            reg_q <= reg_d;
            val_q <= val_d;
            send_q <= send_d;
            done_q <= done_d;
        end
    end

    assign cfg_id = DEVICE_ID;
    assign cfg_reg = reg_q;
    assign cfg_value = val_q;
    assign send = send_q;
    assign done = done_q;
    assign busy = (state_q != DONE);
    assign index = index_q;
endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// tb_sccb_cfg_sequencer: directed checks of table walk, handshake, markers, reset and restart.
module tb_sccb_cfg_sequencer;
    localparam logic [16*256-1:0] ROM_A = {{251{16'hFFFF}}, 16'hFFFF, 16'h1100, 16'h1204, 16'hFFF0, 16'h1280};
    localparam logic [16*4-1:0] ROM_B = {16'h1504, 16'h1403, 16'h1302, 16'h1201};

    logic clk = 1'b0, rst_n = 1'b0, restart = 1'b0, taken = 1'b0;
    logic [7:0] cfg_id, cfg_reg, cfg_value, index;
    logic send, busy, done;
    logic rst_n_b = 1'b0, restart_b = 1'b0, taken_b = 1'b0;
    logic [7:0] cfg_id_b, cfg_reg_b, cfg_value_b;
    logic send_b, busy_b, done_b;
    logic [1:0] index_b, idx_prev_b = 2'd0;
    logic send_prev = 1'b0, send_prev_b = 1'b0, wrap_b = 1'b0;
    int n_chk = 0, n_fail = 0, rises = 0, rises_b = 0;

    sccb_cfg_sequencer #(.ROM_AW(8), .START_DELAY(4), .MARK_DELAY(8), .ROM_INIT(ROM_A)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .cfg_id(cfg_id), .cfg_reg(cfg_reg),
        .cfg_value(cfg_value), .send(send), .taken(taken), .busy(busy), .done(done), .index(index)
    );

    sccb_cfg_sequencer #(.ROM_AW(2), .START_DELAY(4), .MARK_DELAY(8), .ROM_INIT(ROM_B)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .restart(restart_b), .cfg_id(cfg_id_b), .cfg_reg(cfg_reg_b),
        .cfg_value(cfg_value_b), .send(send_b), .taken(taken_b), .busy(busy_b), .done(done_b), .index(index_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        send_prev <= send;
        send_prev_b <= send_b;
        idx_prev_b <= index_b;
        if (send && !send_prev) rises <= rises + 1;
        if (send_b && !send_prev_b) rises_b <= rises_b + 1;
        if (rst_n_b && idx_prev_b == 2'd3 && index_b == 2'd0) wrap_b <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_send(input string tag);
        int n = 0;
        while (send !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_send_seen"}, 32'(send), 1);
    endtask

    // Sender model: called on the negedge where send is first seen high; pulses taken
    // so it is sampled on the third rising edge after send rose (or after a long stall).
    task automatic serve(input string tag, input logic [7:0] r, input logic [7:0] v, input int hold);
        logic stable = 1'b1;
        logic [7:0] idx = index;
        chk({tag, "_reg"}, 32'(cfg_reg), 32'(r));
        chk({tag, "_val"}, 32'(cfg_value), 32'(v));
        repeat (hold) begin
            @(negedge clk);
            if (send !== 1'b1 || cfg_reg !== r || cfg_value !== v || index !== idx) stable = 1'b0;
        end
        chk({tag, "_stable"}, 32'(stable), 1);
        taken = 1'b1;
        @(negedge clk);
        taken = 1'b0;
        chk({tag, "_send_fell"}, 32'(send), 0);
    endtask

    task automatic full_pass(input string tag, input int stall);
        int n, gap, r0;
        @(negedge clk);
        rst_n = 1'b1;
        r0 = rises;
        @(negedge clk);
        taken = 1'b1;
        @(negedge clk);
        taken = 1'b0;
        n = 2;
        while (send !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_first_send_latency"}, 32'(n), 6);
        chk({tag, "_idx0"}, 32'(index), 0);
        serve({tag, "_w1"}, 8'h12, 8'h80, 2);
        repeat (4) @(negedge clk);
        taken = 1'b1;
        @(negedge clk);
        taken = 1'b0;
        gap = 5;
        while (send !== 1'b1 && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        chk({tag, "_marker_gap_ge8"}, 32'(gap >= 8 && gap < 200), 1);
        chk({tag, "_idx2"}, 32'(index), 2);
        serve({tag, "_w2"}, 8'h12, 8'h04, stall);
        wait_send({tag, "_w3"});
        chk({tag, "_idx3"}, 32'(index), 3);
        serve({tag, "_w3"}, 8'h11, 8'h00, 2);
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy_low"}, 32'(busy), 0);
        chk({tag, "_idx_end"}, 32'(index), 4);
        repeat (20) @(negedge clk);
        chk({tag, "_write_count"}, 32'(rises - r0), 3);
        chk({tag, "_done_held"}, 32'(done), 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_send", 32'(send), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_index", 32'(index), 0);
        chk("rst_reg", 32'(cfg_reg), 0);
        chk("rst_val", 32'(cfg_value), 0);
        chk("rst_id", 32'(cfg_id), 32'h42);
        full_pass("p1", 100);

        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_done_low", 32'(done), 0);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_index", 32'(index), 0);
        wait_send("p2_w1");
        serve("p2_w1", 8'h12, 8'h80, 2);
        repeat (3) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("midtable_restart_done", 32'(done), 0);
        chk("midtable_restart_busy", 32'(busy), 1);
        wait_send("p2_w2");
        chk("p2_w2_idx", 32'(index), 2);
        chk("p2_w2_reg", 32'(cfg_reg), 32'h12);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_send", 32'(send), 0);
        chk("async_rst_index", 32'(index), 0);
        chk("async_rst_busy", 32'(busy), 1);
        full_pass("p3", 2);

        @(negedge clk);
        rst_n_b = 1'b1;
        taken_b = 1'b1;
        n = 0;
        while (done_b !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("b_done", 32'(done_b), 1);
        chk("b_index_last", 32'(index_b), 3);
        chk("b_write_count", 32'(rises_b), 4);
        chk("b_no_wrap", 32'(wrap_b), 0);
        chk("b_last_reg", 32'(cfg_reg_b), 32'h15);
        chk("b_last_val", 32'(cfg_value_b), 32'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
